// File: rtl/axi_llc_chan_splitter_mc.sv
// Round-robin AX arbiter feeding a vector FIFO and a per-cache-line burst cutter.
// Optional per-channel descriptor counters: define AXI_LLC_SPLIT_CNT_EN.
module axi_llc_chan_splitter_mc #(
  parameter int unsigned NumChan    = 2,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned LineBytes  = 64,
  parameter int unsigned ChanIdxW   = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChan*AddrWidth-1:0] ax_addr_i,
  input  logic [NumChan*8-1:0]         ax_len_i,
  input  logic [NumChan*3-1:0]         ax_size_i,
  input  logic [NumChan*2-1:0]         ax_burst_i,
  input  logic [NumChan*IdWidth-1:0]   ax_id_i,
  input  logic [NumChan-1:0]           ax_valid_i,
  output logic [NumChan-1:0]           ax_ready_o,
  output logic [AddrWidth-1:0]         desc_addr_o,
  output logic [7:0]                   desc_len_o,
  output logic [2:0]                   desc_size_o,
  output logic [IdWidth-1:0]           desc_id_o,
  output logic [ChanIdxW-1:0]          desc_chan_o,
  output logic                         desc_first_o,
  output logic                         desc_last_o,
  output logic                         desc_valid_o,
  input  logic                         desc_ready_i,
`ifdef AXI_LLC_SPLIT_CNT_EN
  output logic [NumChan*32-1:0]        desc_cnt_o,
`endif
  output logic                         unit_busy_o
);

  localparam int unsigned OffW = $clog2(LineBytes);
  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW = $clog2(QueueDepth + 1);
  localparam logic [OffW:0] LineW = (OffW+1)'(LineBytes);
  localparam logic [AddrWidth-1:0] LineA = AddrWidth'(LineBytes);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [IdWidth-1:0]   id;
    logic [ChanIdxW-1:0]  chan;
  } ax_vec_t;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  state_e state_q, state_d;
  ax_vec_t split_q, split_d;
  logic [ChanIdxW-1:0] rr_q, rr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ax_vec_t fifo_q [QueueDepth];

  logic fifo_empty, fifo_full;
  logic [ChanIdxW-1:0] gnt_idx;
  logic gnt_vld;
  logic push, pop, dhs;
  ax_vec_t push_vec, head, cur;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(QueueDepth));

  // First valid channel at or above rr, wrapping.
  always_comb begin : arb
    int unsigned c;
    logic [ChanIdxW-1:0] ci;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c = 0;
    ci = '0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      c = 32'(rr_q) + i;
      if (c >= NumChan) c = c - NumChan;
      ci = ChanIdxW'(c);
      if (!gnt_vld && ax_valid_i[ci]) begin
        gnt_vld = 1'b1;
        gnt_idx = ci;
      end
    end
  end

  always_comb begin
    push_vec.addr  = ax_addr_i[gnt_idx*AddrWidth +: AddrWidth];
    push_vec.len   = ax_len_i[gnt_idx*8 +: 8];
    push_vec.size  = ax_size_i[gnt_idx*3 +: 3];
    push_vec.burst = ax_burst_i[gnt_idx*2 +: 2];
    push_vec.id    = ax_id_i[gnt_idx*IdWidth +: IdWidth];
    push_vec.chan  = gnt_idx;
  end

  assign head = fifo_q[rptr_q];
  assign cur  = (state_q == SPLIT) ? split_q : head;

  assign desc_valid_o = (state_q == SPLIT) | !fifo_empty;
  assign unit_busy_o  = desc_valid_o;
  assign dhs = desc_valid_o & desc_ready_i;
  assign pop = (state_q == IDLE) & !fifo_empty & desc_ready_i;

  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push = !rst_i & gnt_vld & (!fifo_full | pop);

  always_comb begin
    ax_ready_o = '0;
    if (push) ax_ready_o[gnt_idx] = 1'b1;
  end

  logic [OffW:0] off, span;
  logic [31:0] room, room_m1;
  logic is_incr, last;
  logic [7:0] d_len, next_len;
  logic [AddrWidth-1:0] next_addr;

  always_comb begin
    off     = {1'b0, cur.addr[OffW-1:0]};
    span    = LineW - off;
    room    = 32'(span >> cur.size);
    if (room == 32'd0) room = 32'd1;
    room_m1 = room - 32'd1;
    is_incr = (cur.burst == 2'b01);
    last    = !is_incr | ({24'd0, cur.len} <= room_m1);
    d_len   = last ? cur.len : room_m1[7:0];
    next_len  = cur.len - room[7:0];
    next_addr = (cur.addr & ~(LineA - 1'b1)) + LineA;
  end

  assign desc_addr_o  = cur.addr;
  assign desc_len_o   = d_len;
  assign desc_size_o  = cur.size;
  assign desc_id_o    = cur.id;
  assign desc_chan_o  = cur.chan;
  assign desc_first_o = (state_q == IDLE);
  assign desc_last_o  = last;

  always_comb begin
    state_d = state_q;
    split_d = split_q;
    if (dhs) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        state_d = SPLIT;
        split_d = cur;
        split_d.addr = next_addr;
        split_d.len  = next_len;
      end
    end
  end

  always_comb begin
    rr_d   = rr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      rr_d = (gnt_idx == ChanIdxW'(NumChan - 1)) ? '0 : gnt_idx + 1'b1;
      wptr_d = (wptr_q == PtrW'(QueueDepth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(QueueDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      split_q <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      split_q <= split_d;
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_vec;
  end

`ifdef AXI_LLC_SPLIT_CNT_EN
  logic [31:0] dcnt_q [NumChan];
  logic [31:0] dcnt_d [NumChan];

  always_comb begin
    dcnt_d = dcnt_q;
    if (dhs && (dcnt_q[cur.chan] != '1)) begin
      dcnt_d[cur.chan] = dcnt_q[cur.chan] + 32'd1;
    end
  end

  always_comb begin
    desc_cnt_o = '0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      desc_cnt_o[i*32 +: 32] = dcnt_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumChan; i++) dcnt_q[i] <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end
`endif

endmodule
